icache_nwa_wide: RTL and testbench
==================================

# icache_nwa_wide

Parametrised N-way set-associative instruction cache with a full-line-wide memory refill port, tree pseudo-LRU replacement, a single-cycle flush, and hit/miss/occupancy counters. It sits between the core's instruction fetch port and the wide instruction memory. It replaces the direct-mapped icache where conflict misses dominate. Read-only: no write path and no write-back.

## Interface
- CACHE_SIZE, 1024: total data capacity in bytes.
- NUM_WAYS, 2: associativity. Power of two, 1..8. A value of 1 degenerates to direct-mapped.
- NUM_BLOCKS, 4: 32-bit words per line. Power of two.
- BLOCK_SIZE, 4: bytes per word. Fixed at 4, since the byte offset is always 2 bits.
- Derived values:
  - NUM_SETS = CACHE_SIZE / (NUM_WAYS*NUM_BLOCKS*BLOCK_SIZE)
  - INDEX_BITS = clog2(NUM_SETS)
  - OFFSET_BITS = clog2(NUM_BLOCKS)
  - TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- proc_valid  in  1  fetch request; held high until proc_ready.
- proc_addr  in  32  fetch address; stable while proc_valid is high.
- proc_ready  out  1  one-cycle pulse; proc_rdata is valid in the same cycle.
- proc_rdata  out  32  fetched word.
- flush  in  1  invalidate all lines. Level-sampled; a pulse is sufficient.
- mem_req_valid  out  1  line refill request.
- mem_req_addr  out  32  line-aligned refill address (low OFFSET_BITS+2 bits are zero).
- mem_req_ready  in  1  memory response; mem_req_rdata is valid in the same cycle.
- mem_req_rdata  in  32*NUM_BLOCKS  full line; word k occupies bits [32k+31:32k].
- debug_miss  out  1  high while in MISS.
- hit_count  out  32  accepted hits; wraps at 2^32.
- miss_count  out  32  misses taken; wraps at 2^32.
- occupancy  out  32  number of valid lines, 0..NUM_SETS*NUM_WAYS.

## Operation
- Address split: tag = [31:32-TAG_BITS], set = [INDEX_BITS+OFFSET_BITS+1 : OFFSET_BITS+2], word = [OFFSET_BITS+1:2].
- Per-set state: NUM_WAYS tag/valid/data entries, plus NUM_WAYS-1 tree-PLRU bits.
- FSM states: IDLE, RESP, MISS.
- IDLE:
  - If flush: clear all valid bits and occupancy, then stay in IDLE. Flush has priority over proc_valid.
  - Else if proc_valid and a way hits: assert proc_ready, drive the word from the hit way, update PLRU to point away from the hit way, increment hit_count, go to RESP.
  - Else if proc_valid and no way hits: latch the address, set mem_req_valid=1, set mem_req_addr to the line-aligned address, increment miss_count, go to MISS.
- MISS:
  - Hold mem_req_valid and mem_req_addr until a cycle with mem_req_ready=1.
  - In that cycle:
    - Choose the victim: the lowest-numbered invalid way if one exists, else the PLRU victim.
    - Write the tag, data and valid bit into the victim.
    - Increment occupancy only if the victim was invalid.
    - Update PLRU to point away from the victim.
    - Drop mem_req_valid.
    - Forward the requested word from mem_req_rdata to proc_rdata, and pulse proc_ready only if proc_valid is still high.
    - Go to RESP.
  - A refill is never abandoned. If proc_valid drops mid-miss, the line is still installed.
  - flush seen in MISS is latched as pending and executed in the first IDLE cycle, before any request.
- RESP: proc_ready returns to 0 and proc_valid is ignored; go to IDLE next cycle.
- Hit detection must be unique per set. Two ways holding the same tag in one set is illegal and cannot arise by construction.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: proc_ready=0, mem_req_valid=0, mem_req_addr=0, proc_rdata=0, debug_miss=0, all counters=0.
  - Internal: all valid bits=0, PLRU bits=0, state=IDLE, pending flush=0.
- Reset during MISS drops mem_req_valid immediately. Memory must tolerate the withdrawn request.
- Hit latency: request sampled at edge N produces proc_ready high during cycle N+1. Maximum hit throughput is one fetch per 2 cycles.
- Miss latency: mem_req_valid rises after edge N. proc_ready is high in the cycle following the edge at which mem_req_ready=1 was sampled. Minimum miss latency is 3 cycles with zero-wait memory.
- mem_req_ready is only meaningful while mem_req_valid=1 and is ignored otherwise.
- flush in IDLE takes effect at the next edge. A request that is high in the same cycle is evaluated in the following cycle, against an empty cache.
- Counters wrap silently. occupancy never exceeds NUM_SETS*NUM_WAYS.

## Test plan
- Cold miss then hit, default parameters: fetch 0x0000_0104 with 1-cycle memory returning words {D3,D2,D1,D0} -> proc_ready with D1. Refetch 0x0000_0108 -> hit, D2, proc_ready in the cycle after the request. Expected counters: miss_count=1, hit_count=1, occupancy=1.
- Two-way conflict: fetch 0x0000_0000, 0x0000_0200, 0x0000_0000 (all set 0) -> 2 misses then 1 hit. Fetch 0x0000_0400 -> evicts 0x200 (the PLRU victim). Refetch 0x0000_0000 -> hit. Refetch 0x0000_0200 -> miss.
- Flush: fill 3 lines, pulse flush in IDLE -> occupancy=0. Next fetch of a filled address misses. flush asserted during MISS -> the fill completes, then the cache is emptied in the first IDLE cycle.
- Memory stall: mem_req_ready held low for 10 cycles -> mem_req_valid and mem_req_addr stay stable, debug_miss=1 throughout, proc_ready=0.
- Abandoned request: drop proc_valid while in MISS -> no proc_ready pulse, and the line is installed (the next fetch of it hits).
- Async reset mid-MISS: assert resetn=0 between edges -> mem_req_valid falls at once, all lines are invalid, and the first fetch after reset misses.

Source files
------------

// File: rtl/icache_nwa_wide.sv
// icache_nwa_wide: N-way set-associative read-only instruction cache with a full-line refill port,
// tree pseudo-LRU replacement, single-cycle flush and hit/miss/occupancy counters.
module icache_nwa_wide #(
  parameter int CACHE_SIZE = 1024,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    proc_valid,
  input  logic [31:0]             proc_addr,
  output logic                    proc_ready,
  output logic [31:0]             proc_rdata,
  input  logic                    flush,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic [32*NUM_BLOCKS-1:0] mem_req_rdata,
  output logic                    debug_miss,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             occupancy
);
  localparam int NUM_SETS    = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * BLOCK_SIZE);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int OFFSET_BITS = $clog2(NUM_BLOCKS);
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int IW = INDEX_BITS > 0 ? INDEX_BITS : 1;
  localparam int OW = OFFSET_BITS > 0 ? OFFSET_BITS : 1;
  localparam int LG = $clog2(NUM_WAYS);
  localparam int WW = LG > 0 ? LG : 1;
  localparam int PW = NUM_WAYS > 1 ? NUM_WAYS - 1 : 1;
  localparam int LW = 32 * NUM_BLOCKS;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd1;
  localparam logic [1:0] MISS = 2'd2;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [PW-1:0]       plru_q  [NUM_SETS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [LW-1:0]       data_q  [NUM_SETS][NUM_WAYS];

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mreq_q, mreq_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;
  logic [31:0] occ_q, occ_d;
  logic        fpend_q, fpend_d;

  logic [31:0]         cur_addr;
  logic [TAG_BITS-1:0] tag;
  logic [IW-1:0]       set;
  logic [OW-1:0]       word;
  logic                hit, inv_found, flush_do, fill_en, touch_en;
  logic [WW-1:0]       hit_way, victim, touch_way;

  // Tree bits name the half holding the victim: 0 = left subtree, 1 = right subtree.
  function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] p);
    int n;
    n = 0;
    for (int l = 0; l < LG; l++) n = 2 * n + 1 + int'(p[n]);
    return WW'(n - (NUM_WAYS - 1));
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WW-1:0] w);
    logic [PW-1:0] r;
    logic b;
    int n;
    r = p;
    n = 0;
    for (int l = 0; l < LG; l++) begin
      b = w[LG-1-l];
      r[n] = ~b;
      n = 2 * n + 1 + int'(b);
    end
    return r;
  endfunction

  assign cur_addr = state_q == MISS ? addr_q : proc_addr;
  assign tag      = cur_addr[31 -: TAG_BITS];
  assign set      = NUM_SETS > 1 ? IW'(cur_addr >> (OFFSET_BITS + 2)) : '0;
  assign word     = NUM_BLOCKS > 1 ? OW'(cur_addr >> 2) : '0;

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[set][w] && tag_q[set][w] == tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
  end

  always_comb begin
    inv_found = 1'b0;
    victim = plru_victim(plru_q[set]);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[set][w]) begin
        inv_found = 1'b1;
        victim = WW'(w);
      end
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    mreq_d    = mreq_q;
    maddr_d   = maddr_q;
    addr_d    = addr_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    occ_d     = occ_q;
    fpend_d   = fpend_q | (flush && state_q != IDLE);
    flush_do  = 1'b0;
    fill_en   = 1'b0;
    touch_en  = 1'b0;
    touch_way = hit_way;
    if (state_q == IDLE) begin
      if (flush || fpend_q) begin
        flush_do = 1'b1;
        occ_d    = '0;
        fpend_d  = 1'b0;
      end else if (proc_valid && hit) begin
        ready_d  = 1'b1;
        rdata_d  = data_q[set][hit_way][{word, 5'd0} +: 32];
        touch_en = 1'b1;
        hit_d    = hit_q + 32'd1;
        state_d  = RESP;
      end else if (proc_valid) begin
        addr_d  = proc_addr;
        mreq_d  = 1'b1;
        maddr_d = proc_addr & ~(32'(NUM_BLOCKS) * 32'd4 - 32'd1);
        miss_d  = miss_q + 32'd1;
        state_d = MISS;
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (mem_req_ready) begin
      fill_en   = 1'b1;
      touch_en  = 1'b1;
      touch_way = victim;
      occ_d     = occ_q + {31'd0, inv_found};
      mreq_d    = 1'b0;
      ready_d   = proc_valid;
      rdata_d   = mem_req_rdata[{word, 5'd0} +: 32];
      state_d   = RESP;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      addr_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      occ_q   <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      occ_q   <= occ_d;
      fpend_q <= fpend_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (flush_do)
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      if (fill_en) valid_q[set][victim] <= 1'b1;
      if (touch_en) plru_q[set] <= plru_touch(plru_q[set], touch_way);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[set][victim]  <= tag;
      data_q[set][victim] <= mem_req_rdata;
    end
  end

  assign proc_ready    = ready_q;
  assign proc_rdata    = rdata_q;
  assign mem_req_valid = mreq_q;
  assign mem_req_addr  = maddr_q;
  assign debug_miss    = state_q == MISS;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
  assign occupancy     = occ_q;
endmodule

// File: tb/tb_icache_nwa_wide.sv
// tb_icache_nwa_wide: scoreboard bench for icache_nwa_wide with a variable-latency line memory.
module tb_icache_nwa_wide;
  logic         clk, resetn, proc_valid, proc_ready, flush;
  logic [31:0]  proc_addr, proc_rdata, mem_req_addr, hit_count, miss_count, occupancy;
  logic         mem_req_valid, mem_req_ready, debug_miss;
  logic [127:0] mem_req_rdata;
  int           n_chk = 0, n_err = 0, mem_delay = 0, wcnt = 0;
  logic [31:0]  exp_q[$];

  icache_nwa_wide #(.CACHE_SIZE(1024), .NUM_WAYS(2), .NUM_BLOCKS(4), .BLOCK_SIZE(4)) dut (
    .clk(clk), .resetn(resetn), .proc_valid(proc_valid), .proc_addr(proc_addr),
    .proc_ready(proc_ready), .proc_rdata(proc_rdata), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_req_rdata(mem_req_rdata), .debug_miss(debug_miss), .hit_count(hit_count),
    .miss_count(miss_count), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(a + 32'(4 * k));
    return l;
  endfunction

  task automatic chk_cnt(input logic [31:0] m, input logic [31:0] h, input logic [31:0] o);
    check("miss_count", miss_count, m);
    check("hit_count", hit_count, h);
    check("occupancy", occupancy, o);
  endtask

  initial begin
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_valid && !mem_req_ready) begin
        if (wcnt >= mem_delay) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = line_of(mem_req_addr);
          check("maddr_align", mem_req_addr[3:0], 0);
          wcnt = 0;
        end else wcnt++;
      end else begin
        mem_req_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  always @(negedge clk)
    if (proc_ready) begin
      if (exp_q.size() == 0) check("unexp_ready", proc_ready, 0);
      else check("rdata", proc_rdata, exp_q.pop_front());
    end

  task automatic fetch(input logic [31:0] a, input bit exp_hit, input bit with_flush = 0);
    int cyc = 0;
    exp_q.push_back(mem_word(a));
    proc_valid = 1'b1;
    proc_addr = a;
    flush = with_flush;
    do begin
      @(posedge clk);
      #1;
      flush = 1'b0;
      cyc++;
      if (!proc_ready && !(with_flush && cyc == 1))
        check("miss_hold", {mem_req_valid, debug_miss, mem_req_addr}, {2'b11, a & 32'hFFFF_FFF0});
    end while (!proc_ready && cyc < 100);
    check("ready", proc_ready, 1);
    check("is_hit", cyc == 1, exp_hit);
    proc_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    resetn = 1'b1;
    proc_valid = 1'b0;
    proc_addr = '0;
    flush = 1'b0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", proc_ready, 0);
    check("rst_mreq", {mem_req_valid, mem_req_addr}, 0);
    check("rst_rdata", proc_rdata, 0);
    check("rst_dbg", debug_miss, 0);
    chk_cnt(0, 0, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    // cold miss then hit in the same line
    fetch(32'h104, 0);
    fetch(32'h108, 1);
    chk_cnt(1, 1, 1);
    // set-0 conflicts exercise the PLRU victim
    fetch(32'h000, 0);
    fetch(32'h200, 0);
    fetch(32'h000, 1);
    fetch(32'h400, 0);
    fetch(32'h000, 1);
    fetch(32'h200, 0);
    chk_cnt(5, 3, 3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_occ", occupancy, 0);
    fetch(32'h104, 0);
    fetch(32'h000, 0);
    chk_cnt(7, 3, 2);
    // flush during a miss is deferred until the fill completes
    mem_delay = 3;
    exp_q.push_back(mem_word(32'h200));
    proc_valid = 1'b1;
    proc_addr = 32'h200;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    cyc = 0;
    while (!proc_ready && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("fmiss_ready", proc_ready, 1);
    proc_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fmiss_occ_fill", occupancy, 3);
    @(posedge clk);
    #1;
    check("fmiss_occ_flush", occupancy, 0);
    mem_delay = 0;
    fetch(32'h104, 0);
    fetch(32'h104, 0, 1);
    chk_cnt(10, 3, 1);
    mem_delay = 10;
    fetch(32'h300, 0);
    chk_cnt(11, 3, 2);
    // abandoned request still installs the line
    mem_delay = 4;
    proc_valid = 1'b1;
    proc_addr = 32'h500;
    @(posedge clk);
    #1;
    check("abn_dbg", debug_miss, 1);
    proc_valid = 1'b0;
    cyc = 0;
    while (mem_req_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abn_done", mem_req_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    mem_delay = 0;
    fetch(32'h500, 1);
    chk_cnt(12, 4, 2);
    // asynchronous reset in the middle of a miss
    mem_delay = 20;
    proc_valid = 1'b1;
    proc_addr = 32'h600;
    @(posedge clk);
    #1;
    check("rmiss_pre", mem_req_valid, 1);
    #3 resetn = 1'b0;
    #1;
    check("rmiss_mreq", mem_req_valid, 0);
    check("rmiss_dbg", debug_miss, 0);
    chk_cnt(0, 0, 0);
    proc_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mem_delay = 0;
    @(posedge clk);
    #1;
    fetch(32'h500, 0);
    chk_cnt(1, 0, 1);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
